dm_unit: RTL and testbench

- M-stage data memory. Directly consumes the M-stage control outputs (DMWr, access type) plus ALU address and forwarded store data.
- Word array with byte-lane write enables, so sw/sh/sb write only the addressed lanes.
- Combinational read with lb/lbu/lh/lhu/lw extension; RD feeds the M/W pipeline register.
- Flags misaligned accesses and prints the standard write-trace line for every committed store.

---
 rtl/dm_unit_pkg.sv | 17 +
 rtl/dm_unit_load_ext.sv | 36 +++
 rtl/dm_unit.sv | 96 +++++++++
 tb/tb_dm_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dm_unit_pkg.sv
// Shared definitions for the M-stage data memory: access-type codes, default
// depth and the store trace format.
package dm_unit_pkg;

  typedef enum logic [2:0] {
    DM_W  = 3'b000,
    DM_HU = 3'b001,
    DM_HS = 3'b010,
    DM_BU = 3'b011,
    DM_BS = 3'b100
  } dm_op_e;

  localparam int DM_DEPTH = 3072;

  localparam string DM_TRACE_FMT = "%d@%h: *%h <= %h";

endpackage

// File: rtl/dm_unit_load_ext.sv
// Load alignment: selects the addressed half/byte of a word and applies
// zero or sign extension. Illegal codes fall through to a full-word load.
module load_ext
  import dm_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_op,
  input  logic [31:0] word,
  output logic [31:0] rd
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase

    rd = word;
    case (dm_op)
      DM_HU:   rd = {16'h0000, half_sel};
      DM_HS:   rd = {{16{half_sel[15]}}, half_sel};
      DM_BU:   rd = {24'h000000, byte_sel};
      DM_BS:   rd = {{24{byte_sel[7]}}, byte_sel};
      default: rd = word;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// M-stage data memory: word array with byte-lane writes, combinational
// extended reads, misalignment/range flagging and a store trace.
module dm_unit
  import dm_unit_pkg::*;
#(
  parameter int          DEPTH_WORDS = DM_DEPTH,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        DMWr,
  input  logic [2:0]  DMOp,
  output logic [31:0] RD,
  output logic        AddrErr
);

  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   word_off;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          is_half;
  logic          is_byte;
  logic          addr_err;
  logic [31:0]   rd_word;
  logic [31:0]   ext_rd;
  logic [3:0]    be;
  logic [31:0]   wd_rep;
  logic [31:0]   wr_word_d;
  logic          wr_en_d;

  always_comb begin
    word_off = {2'b00, Addr[31:2]} - {2'b00, ADDR_BASE[31:2]};
    idx      = word_off[IW-1:0];
    in_range = (Addr >= ADDR_BASE) && (word_off < 32'(DEPTH_WORDS));
    is_half  = (DMOp == DM_HU) || (DMOp == DM_HS);
    is_byte  = (DMOp == DM_BU) || (DMOp == DM_BS);
    addr_err = !in_range
             || (is_half && Addr[0])
             || (!is_half && !is_byte && (Addr[1:0] != 2'b00));

    rd_word  = in_range ? mem_q[idx] : 32'h0;

    // Store data is replicated across lanes so the lane enables alone pick the target.
    be     = 4'b1111;
    wd_rep = WD;
    if (is_half) begin
      be     = Addr[1] ? 4'b1100 : 4'b0011;
      wd_rep = {2{WD[15:0]}};
    end else if (is_byte) begin
      be     = 4'b0001 << Addr[1:0];
      wd_rep = {4{WD[7:0]}};
    end

    for (int b = 0; b < 4; b++) begin
      wr_word_d[8*b +: 8] = be[b] ? wd_rep[8*b +: 8] : rd_word[8*b +: 8];
    end
    wr_en_d = DMWr && !addr_err;
  end

  load_ext u_load_ext (
    .addr_lo (Addr[1:0]),
    .dm_op   (DMOp),
    .word    (rd_word),
    .rd      (ext_rd)
  );

  assign RD      = addr_err ? 32'h0 : ext_rd;
  assign AddrErr = addr_err;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: the whole array is cleared on reset because software relies on zeroed data memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wr_en_d) begin
      mem_q[idx] <= wr_word_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && wr_en_d) begin
      $display(DM_TRACE_FMT, $time, PC_M, {Addr[31:2], 2'b00}, wr_word_d);
    end
  end
`endif

endmodule

// File: tb/tb_dm_unit.sv
// Directed bench for dm_unit: a byte-level memory model checked every cycle,
// plus literal expectations for the documented load/store scenarios.
module tb_dm_unit;
  import dm_unit_pkg::*;

  localparam int          DEPTH = 3072;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] PC_M;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        DMWr;
  logic [2:0]  DMOp;
  logic [31:0] RD;
  logic        AddrErr;

  int total;
  int bad;
  bit model_valid;
  logic [31:0] model_mem [DEPTH];

  dm_unit #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .PC_M    (PC_M),
    .Addr    (Addr),
    .WD      (WD),
    .DMWr    (DMWr),
    .DMOp    (DMOp),
    .RD      (RD),
    .AddrErr (AddrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t addr=%h op=%0d)", name, act, exp, $time, Addr, DMOp);
    end
  endtask

  function automatic int m_size(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 2;
    if (op == 3'd3 || op == 3'd4) return 1;
    return 4;
  endfunction

  function automatic bit m_err(input logic [31:0] addr, input logic [2:0] op);
    if (addr < BASE) return 1'b1;
    if (((addr - BASE) / 4) >= DEPTH) return 1'b1;
    if ((addr % m_size(op)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] addr, input logic [2:0] op);
    logic [31:0] w;
    logic [31:0] v;
    int sz;
    if (m_err(addr, op)) return 32'h0;
    w  = model_mem[(addr - BASE) / 4];
    sz = m_size(op);
    if (sz == 4) return w;
    v = (w >> (8 * (addr % 4))) & ((sz == 2) ? 32'hFFFF : 32'hFF);
    if (op == 3'd2 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    if (op == 3'd4 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] addr,
                                          input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] res;
    int off;
    res = old;
    off = addr % 4;
    for (int k = 0; k < m_size(op); k++) begin
      res[8*(off+k) +: 8] = wd[8*k +: 8];
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] <= 32'h0;
      model_valid <= 1'b1;
    end else if (DMWr && !m_err(Addr, DMOp)) begin
      model_mem[(Addr - BASE) / 4] <= m_merge(model_mem[(Addr - BASE) / 4], Addr, DMOp, WD);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("rd_vs_model", RD, m_rd(Addr, DMOp));
      check("err_vs_model", {31'b0, AddrErr}, {31'b0, m_err(Addr, DMOp)});
    end
  end

  task automatic drive(input logic rst, input logic wr, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #2;
    reset = rst;
    DMWr  = wr;
    DMOp  = op;
    Addr  = addr;
    WD    = wd;
    PC_M  = PC_M + 32'd4;
  endtask

  task automatic lit(input string name, input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    #1;
    check({name, "_rd"}, RD, exp_rd);
    check({name, "_err"}, {31'b0, AddrErr}, {31'b0, exp_err});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_valid = 1'b0;
    reset = 1'b1;
    DMWr  = 1'b0;
    DMOp  = DM_W;
    Addr  = 32'h0;
    WD    = 32'h0;
    PC_M  = 32'h0000_3000;

    drive(1'b1, 1'b0, DM_W, 32'h0, 32'h0);
    drive(1'b1, 1'b0, DM_W, 32'h0, 32'h0);

    drive(1'b0, 1'b0, DM_W, 32'h0000_0000, 32'h0); lit("lw0_after_reset", 32'h0, 1'b0);
    drive(1'b0, 1'b0, DM_W, 32'h0000_0004, 32'h0); lit("lw4_after_reset", 32'h0, 1'b0);
    drive(1'b0, 1'b0, DM_W, 32'h0000_2FFC, 32'h0); lit("lw_top_after_reset", 32'h0, 1'b0);

    drive(1'b0, 1'b1, DM_W,  32'h10, 32'h1234_5678);
    drive(1'b0, 1'b0, DM_W,  32'h10, 32'h0); lit("lw_after_sw", 32'h1234_5678, 1'b0);

    drive(1'b0, 1'b1, DM_BU, 32'h13, 32'h0000_00AB);
    drive(1'b0, 1'b0, DM_W,  32'h10, 32'h0); lit("lw_after_sb", 32'hAB34_5678, 1'b0);
    drive(1'b0, 1'b0, DM_BS, 32'h13, 32'h0); lit("lb_13", 32'hFFFF_FFAB, 1'b0);
    drive(1'b0, 1'b0, DM_BU, 32'h13, 32'h0); lit("lbu_13", 32'h0000_00AB, 1'b0);

    drive(1'b0, 1'b1, DM_HU, 32'h10, 32'hFFFF_8001);
    drive(1'b0, 1'b0, DM_W,  32'h10, 32'h0); lit("lw_after_sh", 32'hAB34_8001, 1'b0);
    drive(1'b0, 1'b0, DM_HS, 32'h10, 32'h0); lit("lh_10", 32'hFFFF_8001, 1'b0);
    drive(1'b0, 1'b0, DM_HU, 32'h10, 32'h0); lit("lhu_10", 32'h0000_8001, 1'b0);
    drive(1'b0, 1'b0, DM_HS, 32'h12, 32'h0); lit("lh_12", 32'hFFFF_AB34, 1'b0);

    drive(1'b0, 1'b1, DM_W,  32'h12, 32'h5555_5555); lit("sw_misaligned", 32'h0, 1'b1);
    drive(1'b0, 1'b1, DM_HU, 32'h11, 32'h5555_5555); lit("sh_misaligned", 32'h0, 1'b1);
    drive(1'b0, 1'b0, DM_W,  32'h10, 32'h0); lit("lw_after_bad_stores", 32'hAB34_8001, 1'b0);

    drive(1'b0, 1'b1, DM_W,  32'h2FFC, 32'hCAFE_F00D);
    drive(1'b0, 1'b1, DM_W,  32'h3000, 32'hDEAD_BEEF); lit("sw_out_of_range", 32'h0, 1'b1);
    drive(1'b0, 1'b0, DM_W,  32'h2FFC, 32'h0); lit("lw_top_kept", 32'hCAFE_F00D, 1'b0);

    drive(1'b0, 1'b1, DM_W,  32'h20, 32'h1111_1111);
    drive(1'b1, 1'b1, DM_W,  32'h20, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, DM_W,  32'h20, 32'h0); lit("lw20_after_reset_write", 32'h0, 1'b0);
    drive(1'b0, 1'b0, DM_W,  32'h10, 32'h0); lit("lw10_cleared", 32'h0, 1'b0);
    drive(1'b0, 1'b1, DM_W,  32'h20, 32'h55AA_00FF);
    drive(1'b0, 1'b0, DM_W,  32'h20, 32'h0); lit("lw20_after_store", 32'h55AA_00FF, 1'b0);

    drive(1'b0, 1'b0, 3'b111, 32'h20, 32'h0); lit("illegal_op_word", 32'h55AA_00FF, 1'b0);
    drive(1'b0, 1'b0, 3'b110, 32'h22, 32'h0); lit("illegal_op_misaligned", 32'h0, 1'b1);
    drive(1'b0, 1'b0, DM_BU, 32'h21, 32'h0); lit("lbu_21", 32'h0, 1'b0);
    drive(1'b0, 1'b0, DM_BS, 32'h22, 32'h0); lit("lb_22", 32'hFFFF_FFAA, 1'b0);
    drive(1'b0, 1'b0, DM_HU, 32'h22, 32'h0); lit("lhu_22", 32'h0000_55AA, 1'b0);

    drive(1'b0, 1'b1, DM_BS, 32'h21, 32'h1234_567F);
    drive(1'b0, 1'b0, DM_W,  32'h20, 32'h0); lit("lw_after_sb_signed_op", 32'h55AA_7FFF, 1'b0);
    drive(1'b0, 1'b1, DM_HS, 32'h22, 32'h0000_C3A5);
    drive(1'b0, 1'b0, DM_W,  32'h20, 32'h0); lit("lw_after_sh_upper", 32'hC3A5_7FFF, 1'b0);

    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
